// File: rtl/ysyx_22050535_ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// and hands a registered instruction to decode. Redirects squash in-flight responses.
module ysyx_22050535_ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    output logic                  imem_resp_ready,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_err,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic                  kill, kill_nxt;
    logic                  cap;

    assign imem_req_valid  = (state == S_REQ);
    assign imem_resp_ready = (state == S_WAIT);
    assign inst_valid      = (state == S_HOLD);
    assign imem_req_addr   = pc;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        cap       = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (redirect_valid) pc_nxt = redirect_pc;
            end
            S_REQ: begin
                if (redirect_valid) pc_nxt = redirect_pc;
                if (imem_req_ready) begin
                    state_nxt = S_WAIT;
                    // the request just issued carries the stale pc, so its response must die
                    kill_nxt  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    if (imem_resp_valid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        kill_nxt  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    kill_nxt = 1'b0;
                    if (kill) begin
                        state_nxt = S_REQ;
                    end else begin
                        cap       = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end else if (inst_ready) begin
                    pc_nxt    = pc + ADDR_WIDTH'(4);
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst     <= '0;
            inst_pc  <= RESET_PC;
            inst_err <= 1'b0;
        end else if (cap) begin
            inst     <= imem_resp_data;
            inst_pc  <= pc;
            inst_err <= imem_resp_err;
        end
    end

endmodule
